// File: rtl/nand_page_sequencer_if.sv
// nand_page_sequencer_if: request, sub-engine handshake and address/data-select
// bundle between the test top level, the sub-engines and the page sequencer.
// master = everything outside the sequencer (test top plus sub-engines),
// slave  = the sequencer itself.
interface nand_page_sequencer_if #(
    parameter int COL_W  = 12,
    parameter int ROW_W  = 20,
    parameter int PAGE_W = 8
);
    // request side
    logic              start;
    logic              mode;
    logic [COL_W-1:0]  startCol;
    logic [ROW_W-1:0]  startRow;
    logic [PAGE_W-1:0] numPages;

    // sub-engine done levels
    logic              feedbackCommand;
    logic              feedbackALC;
    logic              feedbackWR;
    logic              feedbackRO;

    // sub-engine launch pulses
    logic              rstCommand;
    logic              rstALC;
    logic              rstWR;
    logic              rstRO;

    // data path / status
    logic              commandSelect;
    logic [1:0]        MUXselectline;
    logic [31:0]       toAddressLine;
    logic              writeEnable;
    logic              forReadInstruction;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        output start, mode, startCol, startRow, numPages,
        output feedbackCommand, feedbackALC, feedbackWR, feedbackRO,
        input  rstCommand, rstALC, rstWR, rstRO,
        input  commandSelect, MUXselectline, toAddressLine,
        input  writeEnable, forReadInstruction, busy, done, error
    );

    modport slave (
        input  start, mode, startCol, startRow, numPages,
        input  feedbackCommand, feedbackALC, feedbackWR, feedbackRO,
        output rstCommand, rstALC, rstWR, rstRO,
        output commandSelect, MUXselectline, toAddressLine,
        output writeEnable, forReadInstruction, busy, done, error
    );
endinterface

// File: rtl/nand_page_sequencer.sv
// nand_page_sequencer: walks a multi-page NAND read or program through the
// command, address-latch, write and read-out sub-engines, one row per page.
// All bus outputs are registered decodes of the current state, so they appear
// one cycle after the state that produces them.
// Optional feature: define NAND_SEQ_TIMEOUT_EN to build a per-WAIT watchdog
// that aborts a stalled phase and raises the sticky error flag.
module nand_page_sequencer #(
    parameter int COL_W  = 12,
    parameter int ROW_W  = 20,
    parameter int PAGE_W = 8,
    parameter int TMO_W  = 10
) (
    input  logic                 CLK,
    input  logic                 reset,
    nand_page_sequencer_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_C1_ISS, S_C1_WT,
        S_AD_ISS, S_AD_WT,
        S_C2_ISS, S_C2_WT,
        S_DA_ISS, S_DA_WT,
        S_NEXT
    } state_t;

    state_t            state_q, state_d, adv;
    logic              mode_q;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [PAGE_W-1:0] pages_q;
    logic              zero_q;

    logic              take_start, last_page, waiting, fb_hit, tmo_fire;
    logic              l_cmd_p0, l_alc_p0, l_wr_p0, l_ro_p0;
    logic [1:0]        mux_p0;
    logic              cs_p0;
    logic              busy_p0, done_p0, we_p0, ro_p0;

    // {column, zero pad, row}; the pad vanishes when COL_W+ROW_W == 32
    function automatic logic [31:0] page_addr(input logic [COL_W-1:0] c,
                                               input logic [ROW_W-1:0] r);
        page_addr = '0;
        page_addr[31 -: COL_W]   = c;
        page_addr[ROW_W-1:0]     = r;
    endfunction

`ifdef NAND_SEQ_TIMEOUT_EN
    // last count value before the counter would reach all-ones
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((1 << TMO_W) - 2);
    logic [TMO_W-1:0] tmo_q;
    logic             error_q;
`endif

    // next-state and phase decode; feedback is only looked at in WAIT states
    always_comb begin
        state_d    = state_q;
        adv        = S_IDLE;
        take_start = 1'b0;
        last_page  = 1'b0;
        waiting    = 1'b0;
        fb_hit     = 1'b0;
        tmo_fire   = 1'b0;
        l_cmd_p0   = 1'b0;
        l_alc_p0   = 1'b0;
        l_wr_p0    = 1'b0;
        l_ro_p0    = 1'b0;
        mux_p0     = 2'b00;
        cs_p0      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    take_start = 1'b1;
                    if (bus.numPages != '0) state_d = S_C1_ISS;
                end
            end
            S_C1_ISS: begin
                l_cmd_p0 = 1'b1;
                state_d  = S_C1_WT;
            end
            S_C1_WT: begin
                waiting = 1'b1;
                fb_hit  = bus.feedbackCommand;
                adv     = S_AD_ISS;
            end
            S_AD_ISS: begin
                mux_p0   = 2'b01;
                l_alc_p0 = 1'b1;
                state_d  = S_AD_WT;
            end
            S_AD_WT: begin
                mux_p0  = 2'b01;
                waiting = 1'b1;
                fb_hit  = bus.feedbackALC;
                adv     = mode_q ? S_DA_ISS : S_C2_ISS;
            end
            S_C2_ISS: begin
                cs_p0    = 1'b1;
                l_cmd_p0 = 1'b1;
                state_d  = S_C2_WT;
            end
            S_C2_WT: begin
                cs_p0   = 1'b1;
                waiting = 1'b1;
                fb_hit  = bus.feedbackCommand;
                adv     = mode_q ? S_NEXT : S_DA_ISS;
            end
            S_DA_ISS: begin
                mux_p0  = mode_q ? 2'b10 : 2'b11;
                l_wr_p0 = mode_q;
                l_ro_p0 = !mode_q;
                state_d = S_DA_WT;
            end
            S_DA_WT: begin
                mux_p0  = mode_q ? 2'b10 : 2'b11;
                waiting = 1'b1;
                fb_hit  = mode_q ? bus.feedbackWR : bus.feedbackRO;
                adv     = mode_q ? S_C2_ISS : S_NEXT;
            end
            S_NEXT: begin
                if (pages_q == PAGE_W'(1)) begin
                    last_page = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_C1_ISS;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (waiting) begin
            if (fb_hit) begin
                state_d = adv;
            end
`ifdef NAND_SEQ_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) begin
                state_d  = S_IDLE;
                tmo_fire = 1'b1;
            end
`endif
        end
    end

    // busy drops together with done, i.e. on the edge that returns to IDLE
    assign busy_p0 = (state_q != S_IDLE) && (state_d != S_IDLE);
    assign done_p0 = zero_q | last_page | tmo_fire;
    assign we_p0   = mode_q && busy_p0;
    assign ro_p0   = !mode_q && (state_q == S_DA_ISS || state_q == S_DA_WT);

    // state register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // request capture and per-page row/count walk
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            mode_q  <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            pages_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            zero_q <= take_start && (bus.numPages == '0);
            if (take_start) begin
                mode_q  <= bus.mode;
                col_q   <= bus.startCol;
                row_q   <= bus.startRow;
                pages_q <= bus.numPages;
            end else if (state_q == S_NEXT) begin
                row_q   <= row_q + 1'b1;
                pages_q <= pages_q - 1'b1;
            end
        end
    end

    // ---- stage boundary: decoded controls -> registered bus outputs ----
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            bus.rstCommand         <= 1'b0;
            bus.rstALC             <= 1'b0;
            bus.rstWR              <= 1'b0;
            bus.rstRO              <= 1'b0;
            bus.commandSelect      <= 1'b0;
            bus.MUXselectline      <= 2'b00;
            bus.toAddressLine      <= '0;
            bus.writeEnable        <= 1'b0;
            bus.forReadInstruction <= 1'b0;
            bus.busy               <= 1'b0;
            bus.done               <= 1'b0;
        end else begin
            bus.rstCommand         <= l_cmd_p0;
            bus.rstALC             <= l_alc_p0;
            bus.rstWR              <= l_wr_p0;
            bus.rstRO              <= l_ro_p0;
            bus.commandSelect      <= cs_p0;
            bus.MUXselectline      <= mux_p0;
            bus.writeEnable        <= we_p0;
            bus.forReadInstruction <= ro_p0;
            bus.busy               <= busy_p0;
            bus.done               <= done_p0;
            if (state_q == S_C1_ISS) bus.toAddressLine <= page_addr(col_q, row_q);
        end
    end

`ifdef NAND_SEQ_TIMEOUT_EN
    // WAIT watchdog and sticky error; counter idles at 0 outside WAIT
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            tmo_q   <= '0;
            error_q <= 1'b0;
        end else begin
            if (waiting && !fb_hit && !tmo_fire) tmo_q <= tmo_q + 1'b1;
            else                                 tmo_q <= '0;
            if (take_start)    error_q <= 1'b0;
            else if (tmo_fire) error_q <= 1'b1;
        end
    end
    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

endmodule

// File: tb/tb_nand_page_sequencer.sv
// tb_nand_page_sequencer: directed vectors for the page sequencer with a
// behavioural sub-engine responder and a launch-pulse log.
`timescale 1ns/1ps
module tb_nand_page_sequencer;

`ifdef NAND_SEQ_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 10;
`endif

    logic CLK = 1'b0;
    logic reset;

    nand_page_sequencer_if #(.COL_W(12), .ROW_W(20), .PAGE_W(8)) bus ();

    nand_page_sequencer #(.COL_W(12), .ROW_W(20), .PAGE_W(8), .TMO_W(TMO)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;

    // launch log: 0 command, 1 ALC, 2 WR, 3 RO
    int lg_cyc[$], lg_code[$], lg_cs[$], lg_mux[$], lg_we[$], lg_ro[$];
    longint lg_addr[$];
    int done_cnt = 0;
    int last_done_cyc = 0;
    bit busy_seen = 0;
    bit hold_alc = 0;
    bit block_ro = 0;

    task automatic check_vec(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic log_launch(input int s, input int code);
        lg_cyc.push_back(s);
        lg_code.push_back(code);
        lg_cs.push_back(int'(bus.commandSelect));
        lg_mux.push_back(int'(bus.MUXselectline));
        lg_we.push_back(int'(bus.writeEnable));
        lg_ro.push_back(int'(bus.forReadInstruction));
        lg_addr.push_back(longint'(bus.toAddressLine));
    endtask

    // sub-engine model: answers each launch in the cycle it becomes visible
    initial begin
        bus.feedbackCommand = 1'b0;
        bus.feedbackALC     = 1'b0;
        bus.feedbackWR      = 1'b0;
        bus.feedbackRO      = 1'b0;
        forever begin
            @(negedge CLK);
            if (bus.rstCommand) log_launch(int'($time / 10), 0);
            if (bus.rstALC)     log_launch(int'($time / 10), 1);
            if (bus.rstWR)      log_launch(int'($time / 10), 2);
            if (bus.rstRO)      log_launch(int'($time / 10), 3);
            if (bus.done) begin
                done_cnt++;
                last_done_cyc = int'($time / 10);
            end
            if (bus.busy) busy_seen = 1;
            bus.feedbackCommand = bus.rstCommand;
            bus.feedbackALC     = bus.rstALC | hold_alc;
            bus.feedbackWR      = bus.rstWR;
            bus.feedbackRO      = bus.rstRO & !block_ro;
        end
    end

    task automatic clear_log();
        lg_cyc.delete(); lg_code.delete(); lg_cs.delete(); lg_mux.delete();
        lg_we.delete(); lg_ro.delete(); lg_addr.delete();
        busy_seen = 0;
    endtask

    // drive one start pulse; s = stamp of the cycle start is driven in
    task automatic run_op(input bit m, input int col, input int row, input int pages, output int s);
        clear_log();
        s = int'($time / 10);
        bus.start    = 1'b1;
        bus.mode     = m;
        bus.startCol = 12'(col);
        bus.startRow = 20'(row);
        bus.numPages = 8'(pages);
        @(negedge CLK); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int stamp);
        int n = 0;
        int c0 = done_cnt;
        while (done_cnt == c0 && n < budget) begin
            @(negedge CLK); #1;
            n++;
        end
        check_vec({tag, "_done_seen"}, done_cnt - c0, 1);
        stamp = last_done_cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK); #1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_vec({tag, "_rstCommand"}, bus.rstCommand, 0);
        check_vec({tag, "_rstALC"}, bus.rstALC, 0);
        check_vec({tag, "_rstWR"}, bus.rstWR, 0);
        check_vec({tag, "_rstRO"}, bus.rstRO, 0);
        check_vec({tag, "_cmdSel"}, bus.commandSelect, 0);
        check_vec({tag, "_mux"}, bus.MUXselectline, 0);
        check_vec({tag, "_addr"}, bus.toAddressLine, 0);
        check_vec({tag, "_we"}, bus.writeEnable, 0);
        check_vec({tag, "_forRead"}, bus.forReadInstruction, 0);
        check_vec({tag, "_busy"}, bus.busy, 0);
        check_vec({tag, "_done"}, bus.done, 0);
        check_vec({tag, "_error"}, bus.error, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int s, d, r, n0, dc0;
        int exp_rd[4]  = '{0, 1, 0, 3};
        int exp_rcs[4] = '{0, 0, 1, 0};
        int exp_rmx[4] = '{0, 1, 0, 3};
        int exp_pg[4]  = '{0, 1, 2, 0};
        int exp_pcs[4] = '{0, 0, 0, 1};
        int exp_pmx[4] = '{0, 1, 2, 0};
        longint exp_addr;

        reset = 1'b1;
        bus.start = 1'b0; bus.mode = 1'b0;
        bus.startCol = '0; bus.startRow = '0; bus.numPages = '0;
        #22;
        check_reset_vals("reset");
        @(negedge CLK); #1;
        reset = 1'b0;
        idle(2);

        // read, one page, col 0x004 row 0x00010
        run_op(1'b0, 12'h004, 20'h00010, 1, s);
        wait_done("rd1", 50, d);
        check_vec("rd1_launches", lg_cyc.size(), 4);
        if (lg_cyc.size() == 4) begin
            check_vec("rd1_first_latency", lg_cyc[0] - s - 1, 1);
            for (int i = 0; i < 4; i++) begin
                check_vec($sformatf("rd1_code%0d", i), lg_code[i], exp_rd[i]);
                check_vec($sformatf("rd1_cs%0d", i), lg_cs[i], exp_rcs[i]);
                check_vec($sformatf("rd1_mux%0d", i), lg_mux[i], exp_rmx[i]);
                check_vec($sformatf("rd1_addr%0d", i), lg_addr[i], 64'h00400010);
                check_vec($sformatf("rd1_we%0d", i), lg_we[i], 0);
                if (i > 0) check_vec($sformatf("rd1_gap%0d", i), lg_cyc[i] - lg_cyc[i-1], 2);
            end
            check_vec("rd1_forRead_in_RO", lg_ro[3], 1);
        end
        check_vec("rd1_done_latency", d - s - 1, 9);
        check_vec("rd1_busy_after", bus.busy, 0);
        idle(2);

        // program, three pages from row 5
        dc0 = done_cnt;
        run_op(1'b1, 12'h123, 20'h00005, 3, s);
        wait_done("pg3", 100, d);
        idle(3);
        check_vec("pg3_done_count", done_cnt - dc0, 1);
        check_vec("pg3_done_latency", d - s - 1, 27);
        check_vec("pg3_launches", lg_cyc.size(), 12);
        if (lg_cyc.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                exp_addr = 64'h12300000 + 64'(5 + i / 4);
                check_vec($sformatf("pg3_code%0d", i), lg_code[i], exp_pg[i % 4]);
                check_vec($sformatf("pg3_cs%0d", i), lg_cs[i], exp_pcs[i % 4]);
                check_vec($sformatf("pg3_mux%0d", i), lg_mux[i], exp_pmx[i % 4]);
                check_vec($sformatf("pg3_we%0d", i), lg_we[i], 1);
                check_vec($sformatf("pg3_addr%0d", i), lg_addr[i], exp_addr);
            end
        end
        check_vec("pg3_we_after", bus.writeEnable, 0);

        // row wrap from all-ones
        run_op(1'b0, 12'h000, 20'hFFFFF, 2, s);
        wait_done("wrap", 60, d);
        check_vec("wrap_launches", lg_cyc.size(), 8);
        if (lg_cyc.size() == 8) begin
            check_vec("wrap_page1_addr", lg_addr[0], 64'h000FFFFF);
            check_vec("wrap_page2_addr", lg_addr[4], 64'h00000000);
        end
        idle(2);

        // zero pages
        run_op(1'b1, 12'h0AA, 20'h00123, 0, s);
        wait_done("zero", 10, d);
        check_vec("zero_done_latency", d - s - 1, 1);
        idle(3);
        check_vec("zero_launches", lg_cyc.size(), 0);
        check_vec("zero_busy_seen", busy_seen, 0);

        // ALC feedback held high, plus a start while busy
        hold_alc = 1;
        dc0 = done_cnt;
        run_op(1'b0, 12'h004, 20'h00010, 1, s);
        idle(2);
        bus.start = 1'b1; bus.mode = 1'b1; bus.startCol = 12'hFFF;
        bus.startRow = 20'h00777; bus.numPages = 8'd5;
        idle(1);
        bus.start = 1'b0;
        wait_done("hold", 50, d);
        hold_alc = 0;
        idle(3);
        check_vec("hold_launches", lg_cyc.size(), 4);
        if (lg_cyc.size() == 4) begin
            check_vec("hold_alc_code", lg_code[1], 1);
            check_vec("hold_alc_gap", lg_cyc[2] - lg_cyc[1], 2);
            check_vec("hold_cmd1_gap", lg_cyc[1] - lg_cyc[0], 2);
            check_vec("hold_last_code", lg_code[3], 3);
            check_vec("hold_addr", lg_addr[3], 64'h00400010);
        end
        check_vec("hold_done_count", done_cnt - dc0, 1);
        check_vec("hold_done_latency", d - s - 1, 9);

        // stalled read-out
        block_ro = 1;
        dc0 = done_cnt;
        run_op(1'b0, 12'h001, 20'h00002, 1, s);
`ifdef NAND_SEQ_TIMEOUT_EN
        wait_done("tmo", 60, d);
        r = -100;
        foreach (lg_code[i]) if (lg_code[i] == 3) r = lg_cyc[i];
        check_vec("tmo_done_after_ro", d - r, 15);
        check_vec("tmo_error_set", bus.error, 1);
        check_vec("tmo_busy", bus.busy, 0);
        block_ro = 0;
        idle(2);
        check_vec("tmo_error_sticky", bus.error, 1);
        run_op(1'b0, 12'h001, 20'h00002, 1, s);
        check_vec("tmo_error_cleared", bus.error, 0);
        wait_done("tmo_retry", 50, d);
        check_vec("tmo_retry_error", bus.error, 0);
`else
        idle(40);
        check_vec("stall_no_done", done_cnt - dc0, 0);
        check_vec("stall_busy", bus.busy, 1);
        check_vec("stall_error", bus.error, 0);
        check_vec("stall_forRead", bus.forReadInstruction, 1);
        @(negedge CLK); #3;
        reset = 1'b1;
        #1;
        check_reset_vals("stall_reset");
        @(negedge CLK); #1;
        reset = 1'b0;
        block_ro = 0;
`endif
        idle(2);

        // asynchronous reset in the middle of a program page
        run_op(1'b1, 12'h321, 20'h00040, 2, s);
        idle(4);
        check_vec("mid_busy_before", bus.busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("mid_reset");
        @(negedge CLK); #1;
        reset = 1'b0;
        n0 = lg_cyc.size();
        idle(4);
        check_vec("mid_no_relaunch", lg_cyc.size() - n0, 0);
        check_vec("mid_busy_after", bus.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
